sid_mac_scheduler: RTL and testbench

//   Time-multiplexes one shared 16x16 signed*unsigned multiplier (one SB_MAC16

---
 rtl/sid_mac_scheduler.sv | 165 ++++++++++++++++
 tb/tb_sid_mac_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_mac_scheduler.sv
// Shares one registered signed*unsigned multiplier across the three SID voice
// envelope products and the master-volume product, one fixed schedule per start.
module sid_mac_scheduler #(
  parameter int MAC_LAT = 2,
  parameter int MIX_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] voice0_i,
  input  logic [11:0] voice1_i,
  input  logic [11:0] voice2_i,
  input  logic [7:0]  env0_i,
  input  logic [7:0]  env1_i,
  input  logic [7:0]  env2_i,
  input  logic [15:0] mixIn_i,
  input  logic [3:0]  vol_i,
  output logic [15:0] mulA_o,
  output logic [15:0] mulB_o,
  input  logic [31:0] mulP_i,
  output logic [15:0] amp0_o,
  output logic [15:0] amp1_o,
  output logic [15:0] amp2_o,
  output logic        ampValid_o,
  output logic [15:0] out_o,
  output logic        outValid_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int AMP_LAST  = 2 + MAC_LAT;
  localparam int MIX_ISSUE = AMP_LAST + MIX_LAT;
  localparam int DONE      = MIX_ISSUE + MAC_LAT;
  localparam int CW        = $clog2(DONE + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE_V, DRAIN_V, MIX_WAIT, ISSUE_M, DRAIN_M
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [15:0]   mulA_q, mulA_d, mulB_q, mulB_d;
  logic [15:0]   amp0_q, amp0_d, amp1_q, amp1_d, amp2_q, amp2_d;
  logic [15:0]   out_q, out_d;
  logic          ampValid_q, ampValid_d, outValid_q, outValid_d;
  logic          busy_q, busy_d, overrun_q, overrun_d;

  logic [15:0]   ampSlice, outSlice;
  logic          unusedMulP;

  assign ampSlice   = mulP_i[23:8];
  assign outSlice   = mulP_i[19:4];
  assign unusedMulP = ^{mulP_i[31:24], mulP_i[3:0]};

  // cyc_q holds k of the upcoming edge Ek while a schedule is running
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    mulA_d     = '0;
    mulB_d     = '0;
    amp0_d     = amp0_q;
    amp1_d     = amp1_q;
    amp2_d     = amp2_q;
    out_d      = out_q;
    ampValid_d = 1'b0;
    outValid_d = 1'b0;
    busy_d     = busy_q;
    overrun_d  = start_i && busy_q;

    if (state_q != IDLE) begin
      cyc_d = cyc_q + CW'(1);
      if (cyc_q == CW'(MAC_LAT))     amp0_d = ampSlice;
      if (cyc_q == CW'(MAC_LAT + 1)) amp1_d = ampSlice;
      if (cyc_q == CW'(AMP_LAST)) begin
        amp2_d     = ampSlice;
        ampValid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE_V;
          cyc_d   = CW'(1);
          busy_d  = 1'b1;
          mulA_d  = {voice0_i, 4'b0};
          mulB_d  = {8'b0, env0_i};
        end
      end
      ISSUE_V: begin
        if (cyc_q == CW'(1)) begin
          mulA_d = {voice1_i, 4'b0};
          mulB_d = {8'b0, env1_i};
        end else begin
          mulA_d  = {voice2_i, 4'b0};
          mulB_d  = {8'b0, env2_i};
          state_d = DRAIN_V;
        end
      end
      DRAIN_V: begin
        if (cyc_q == CW'(AMP_LAST)) state_d = (MIX_LAT == 1) ? ISSUE_M : MIX_WAIT;
      end
      MIX_WAIT: begin
        if (cyc_q == CW'(MIX_ISSUE - 1)) state_d = ISSUE_M;
      end
      ISSUE_M: begin
        mulA_d  = mixIn_i;
        mulB_d  = {12'b0, vol_i};
        state_d = DRAIN_M;
      end
      DRAIN_M: begin
        if (cyc_q == CW'(DONE)) begin
          out_d      = outSlice;
          outValid_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
          cyc_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      amp0_q     <= '0;
      amp1_q     <= '0;
      amp2_q     <= '0;
      out_q      <= '0;
      ampValid_q <= 1'b0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      amp0_q     <= amp0_d;
      amp1_q     <= amp1_d;
      amp2_q     <= amp2_d;
      out_q      <= out_d;
      ampValid_q <= ampValid_d;
      outValid_q <= outValid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign mulA_o     = mulA_q;
  assign mulB_o     = mulB_q;
  assign amp0_o     = amp0_q;
  assign amp1_o     = amp1_q;
  assign amp2_o     = amp2_q;
  assign out_o      = out_q;
  assign ampValid_o = ampValid_q;
  assign outValid_o = outValid_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sid_mac_scheduler.sv
// Bench for sid_mac_scheduler: behavioural two-stage multiplier, per-cycle trace
// of each schedule, and a scoreboard of expected amplitudes and master output.
module tb_sid_mac_scheduler;

  localparam int MAC_LAT   = 2;
  localparam int MIX_LAT   = 3;
  localparam int AMP_LAST  = 2 + MAC_LAT;
  localparam int MIX_ISSUE = AMP_LAST + MIX_LAT;
  localparam int DONE      = MIX_ISSUE + MAC_LAT;
  localparam int NSCHED    = DONE + 1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] voice0, voice1, voice2;
  logic [7:0]  env0, env1, env2;
  logic [15:0] mixIn;
  logic [3:0]  vol;
  logic [15:0] mulA, mulB;
  logic [31:0] mulP;
  logic [15:0] amp0, amp1, amp2, out;
  logic        ampValid, outValid, busy, overrun;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
  } ampExp_t;

  ampExp_t     ampQ[$];
  logic [15:0] outQ[$];

  logic [15:0] obsAmp0 [NSCHED];
  logic [15:0] obsAmp1 [NSCHED];
  logic [15:0] obsAmp2 [NSCHED];
  logic [15:0] obsOut  [NSCHED];
  logic [15:0] obsMulA [NSCHED];
  logic [15:0] obsMulB [NSCHED];
  logic        obsAv   [NSCHED];
  logic        obsOvld [NSCHED];
  logic        obsBusy [NSCHED];
  logic        obsOvr  [NSCHED];

  sid_mac_scheduler #(.MAC_LAT(MAC_LAT), .MIX_LAT(MIX_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .voice0_i(voice0), .voice1_i(voice1), .voice2_i(voice2),
    .env0_i(env0), .env1_i(env1), .env2_i(env2),
    .mixIn_i(mixIn), .vol_i(vol),
    .mulA_o(mulA), .mulB_o(mulB), .mulP_i(mulP),
    .amp0_o(amp0), .amp1_o(amp1), .amp2_o(amp2), .ampValid_o(ampValid),
    .out_o(out), .outValid_o(outValid), .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] macProduct(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'(b);
    return p[31:0];
  endfunction

  function automatic logic [15:0] ampRef(input logic [11:0] v, input logic [7:0] e);
    longint p;
    p = longint'($signed(v)) * 16 * longint'(e);
    return p[23:8];
  endfunction

  function automatic logic [15:0] outRef(input logic [15:0] m, input logic [3:0] vl);
    longint p;
    p = longint'($signed(m)) * longint'(vl);
    return p[19:4];
  endfunction

  // The operand register inside the DUT plus this product register give MAC_LAT = 2
  logic [31:0] macPipe = '0;
  always @(posedge clk) macPipe <= macProduct(mulA, mulB);
  assign mulP = macPipe;

  // Drives one schedule (E0..E(DONE)), traces outputs after each edge, checks the scoreboard
  task automatic applyStimulus(input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                               input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [15:0] m, input logic [3:0] vl,
                               input logic [NSCHED-1:0] startMask, input int rstAt);
    ampExp_t ex;
    if (rstAt < 0 || rstAt > AMP_LAST) ampQ.push_back('{ampRef(v0, e0), ampRef(v1, e1), ampRef(v2, e2)});
    if (rstAt < 0) outQ.push_back(outRef(m, vl));
    for (int k = 0; k < NSCHED; k++) begin
      voice0 = (k == 0) ? v0 : 12'($urandom);
      voice1 = (k == 1) ? v1 : 12'($urandom);
      voice2 = (k == 2) ? v2 : 12'($urandom);
      env0   = (k == 0) ? e0 : 8'($urandom);
      env1   = (k == 1) ? e1 : 8'($urandom);
      env2   = (k == 2) ? e2 : 8'($urandom);
      mixIn  = (k == MIX_ISSUE) ? m : 16'($urandom);
      vol    = (k == MIX_ISSUE) ? vl : 4'($urandom);
      start  = (k == 0) ? 1'b1 : startMask[k];
      rst    = (k == rstAt);
      @(negedge clk);
      obsAmp0[k] = amp0;  obsAmp1[k] = amp1;  obsAmp2[k] = amp2;  obsOut[k] = out;
      obsMulA[k] = mulA;  obsMulB[k] = mulB;  obsAv[k] = ampValid; obsOvld[k] = outValid;
      obsBusy[k] = busy;  obsOvr[k] = overrun;
      if (ampValid) begin
        vectors++;
        if (ampQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL ampUnexpected k=%0d: got AMP_VALID=1 expected no pulse", k);
        end else begin
          ex = ampQ.pop_front();
          if ({amp0, amp1, amp2} !== {ex.a0, ex.a1, ex.a2}) begin
            miscompares++;
            $display("[TB] FAIL ampValue: got %h %h %h expected %h %h %h",
                     amp0, amp1, amp2, ex.a0, ex.a1, ex.a2);
          end
        end
      end
      if (outValid) begin
        vectors++;
        if (outQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL outUnexpected k=%0d: got OUT_VALID=1 expected no pulse", k);
        end else if (out !== outQ[0]) begin
          miscompares++;
          $display("[TB] FAIL outValue: got %h expected %h", out, outQ.pop_front());
        end else begin
          void'(outQ.pop_front());
        end
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mulA, mulB, amp0, amp1, amp2, out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL resetData: got %h expected 0", {mulA, mulB, amp0, amp1, amp2, out});
    end
    vectors++;
    if ({ampValid, outValid, busy, overrun} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL resetFlags: got %b expected 0000", {ampValid, outValid, busy, overrun});
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idleBusy: got %b expected 0", busy);
    end
  endtask

  task automatic test_voice_amps;
    applyStimulus(12'h7FF, 12'h800, 12'h123, 8'hFF, 8'h80, 8'h00, 16'h1000, 4'h2, '0, -1);
    vectors++;
    if (obsAmp0[1] !== 16'h0000 || obsAmp0[2] !== 16'h7F70) begin
      miscompares++;
      $display("[TB] FAIL amp0Timing: got %h/%h expected 0000/7f70", obsAmp0[1], obsAmp0[2]);
    end
    vectors++;
    if (obsAmp1[3] !== 16'hC000) begin
      miscompares++;
      $display("[TB] FAIL amp1: got %h expected c000", obsAmp1[3]);
    end
    vectors++;
    if (obsAmp2[4] !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL amp2: got %h expected 0000", obsAmp2[4]);
    end
    for (int k = 0; k < NSCHED; k++) begin
      vectors++;
      if (obsAv[k] !== (k == AMP_LAST)) begin
        miscompares++;
        $display("[TB] FAIL ampValidPulse k=%0d: got %b expected %b", k, obsAv[k], k == AMP_LAST);
      end
    end
    vectors++;
    if ({obsMulA[0], obsMulA[1], obsMulA[2], obsMulA[3], obsMulA[MIX_ISSUE]} !==
        {16'h7FF0, 16'h8000, 16'h1230, 16'h0000, 16'h1000}) begin
      miscompares++;
      $display("[TB] FAIL mulASlots: got %h %h %h %h %h expected 7ff0 8000 1230 0000 1000",
               obsMulA[0], obsMulA[1], obsMulA[2], obsMulA[3], obsMulA[MIX_ISSUE]);
    end
    vectors++;
    if ({obsMulB[0], obsMulB[1], obsMulB[2], obsMulB[MIX_ISSUE]} !==
        {16'h00FF, 16'h0080, 16'h0000, 16'h0002}) begin
      miscompares++;
      $display("[TB] FAIL mulBSlots: got %h %h %h %h expected 00ff 0080 0000 0002",
               obsMulB[0], obsMulB[1], obsMulB[2], obsMulB[MIX_ISSUE]);
    end
  endtask

  task automatic test_master_volume;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busyBeforeE0: got %b expected 0", busy);
    end
    applyStimulus(12'h111, 12'h222, 12'h333, 8'h11, 8'h22, 8'h33, 16'h4000, 4'hF, '0, -1);
    vectors++;
    if (obsOut[DONE-1] !== 16'h0200 || obsOut[DONE] !== 16'h3C00) begin
      miscompares++;
      $display("[TB] FAIL outTiming: got %h/%h expected 0200/3c00", obsOut[DONE-1], obsOut[DONE]);
    end
    for (int k = 0; k < NSCHED; k++) begin
      vectors++;
      if (obsOvld[k] !== (k == DONE) || obsBusy[k] !== (k < DONE)) begin
        miscompares++;
        $display("[TB] FAIL busyOutValid k=%0d: got busy=%b valid=%b expected busy=%b valid=%b",
                 k, obsBusy[k], obsOvld[k], k < DONE, k == DONE);
      end
    end
    applyStimulus(12'h456, 12'h789, 12'hABC, 8'h12, 8'h34, 8'h56, 16'h7FFF, 4'h0, '0, -1);
    vectors++;
    if (obsOut[DONE] !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL outVolZero: got %h expected 0000", obsOut[DONE]);
    end
  endtask

  task automatic test_back_to_back;
    logic [NSCHED-1:0] mask;
    mask = '0;
    mask[AMP_LAST] = 1'b1;
    mask[DONE] = 1'b1;
    applyStimulus(12'h0F0, 12'hF0F, 12'h5A5, 8'hC3, 8'h3C, 8'h99, 16'hC001, 4'h7, mask, -1);
    for (int k = 0; k < NSCHED; k++) begin
      vectors++;
      if (obsOvr[k] !== (k == AMP_LAST || k == DONE)) begin
        miscompares++;
        $display("[TB] FAIL overrunPulse k=%0d: got %b expected %b", k, obsOvr[k],
                 k == AMP_LAST || k == DONE);
      end
    end
    vectors++;
    if (obsAv[AMP_LAST] !== 1'b1 || obsOvld[DONE] !== 1'b1 || obsBusy[DONE-1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrunTiming: got av=%b ov=%b busy=%b expected 1 1 1",
               obsAv[AMP_LAST], obsOvld[DONE], obsBusy[DONE-1]);
    end
    applyStimulus(12'h321, 12'h654, 12'h987, 8'h0F, 8'hF0, 8'h77, 16'h2345, 4'h9, '0, -1);
    vectors++;
    if (obsBusy[0] !== 1'b1 || obsOvr[0] !== 1'b0 || obsOvld[DONE] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL startAtE10: got busy=%b ovr=%b valid=%b expected 1 0 1",
               obsBusy[0], obsOvr[0], obsOvld[DONE]);
    end
  endtask

  task automatic test_mid_reset;
    logic [NSCHED-1:0] mask;
    mask = '0;
    mask[5] = 1'b1;
    applyStimulus(12'h100, 12'h200, 12'h300, 8'h10, 8'h20, 8'h30, 16'h5555, 4'hA, mask, 5);
    vectors++;
    if (obsAmp0[AMP_LAST] !== 16'h0100) begin
      miscompares++;
      $display("[TB] FAIL ampBeforeReset: got %h expected 0100", obsAmp0[AMP_LAST]);
    end
    vectors++;
    if ({obsMulA[5], obsMulB[5], obsAmp0[5], obsAmp1[5], obsAmp2[5], obsOut[5]} !== '0 ||
        {obsAv[5], obsOvld[5], obsBusy[5], obsOvr[5]} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL resetMidSchedule: got amp0=%h out=%h busy=%b ovr=%b expected all 0",
               obsAmp0[5], obsOut[5], obsBusy[5], obsOvr[5]);
    end
    for (int k = 5; k < NSCHED; k++) begin
      vectors++;
      if (obsOvld[k] !== 1'b0 || obsBusy[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abortedSchedule k=%0d: got valid=%b busy=%b expected 0 0",
                 k, obsOvld[k], obsBusy[k]);
      end
    end
    applyStimulus(12'hFFF, 12'h001, 12'h7FF, 8'h01, 8'hFF, 8'hFF, 16'h8000, 4'hF, '0, -1);
    vectors++;
    if (obsAv[AMP_LAST] !== 1'b1 || obsOvld[DONE] !== 1'b1 || obsBusy[DONE-1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cleanAfterReset: got av=%b ov=%b busy=%b expected 1 1 1",
               obsAv[AMP_LAST], obsOvld[DONE], obsBusy[DONE-1]);
    end
  endtask

  task automatic test_random;
    logic [11:0] v [3];
    logic [7:0]  e [3];
    logic [15:0] m, expA, expB;
    logic [3:0]  vl;
    for (int s = 0; s < 1000; s++) begin
      for (int n = 0; n < 3; n++) begin
        v[n] = 12'($urandom);
        e[n] = 8'($urandom);
      end
      m  = 16'($urandom);
      vl = 4'($urandom);
      applyStimulus(v[0], v[1], v[2], e[0], e[1], e[2], m, vl, '0, -1);
      for (int k = 0; k < NSCHED; k++) begin
        expA = 16'h0;
        expB = 16'h0;
        if (k < 3) begin
          expA = {v[k], 4'h0};
          expB = {8'h0, e[k]};
        end else if (k == MIX_ISSUE) begin
          expA = m;
          expB = {12'h0, vl};
        end
        vectors++;
        if (obsMulA[k] !== expA || obsMulB[k] !== expB) begin
          miscompares++;
          $display("[TB] FAIL operands s=%0d k=%0d: got %h*%h expected %h*%h",
                   s, k, obsMulA[k], obsMulB[k], expA, expB);
        end
      end
      repeat (16 - NSCHED) begin
        @(negedge clk);
        vectors++;
        if ({mulA, mulB} !== 32'h0 || ampValid !== 1'b0 || outValid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL idleGap s=%0d: got %h %h av=%b ov=%b expected 0", s, mulA, mulB,
                   ampValid, outValid);
        end
      end
    end
  endtask

  task automatic checkOutput;
    vectors++;
    if (ampQ.size() != 0 || outQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboardDrain: got %0d/%0d pending expected 0/0", ampQ.size(), outQ.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    voice0 = '0; voice1 = '0; voice2 = '0;
    env0 = '0; env1 = '0; env2 = '0;
    mixIn = '0; vol = '0;
    test_reset();
    test_voice_amps();
    test_master_volume();
    test_back_to_back();
    test_mid_reset();
    test_random();
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
